// File: rtl/n64a_vdemux.sv
// n64a_vdemux
// Demultiplexes the N64 video bus into one packed pixel per sync period.
// Each pixel arrives as four consecutive words: a sync word carrying
// {nVSYNC,nCLAMP,nHSYNC,nCSYNC}, then R, G and B.
//
// Ports
//   VCLK          : sole clock, rising edge
//   RST           : synchronous, active-high reset
//   nDSYNC        : low marks the sync word of a pixel
//   D_i           : multiplexed video data bus
//   vdata_o       : registered pixel {S[3:0],R,G,B}, held between strobes
//   vdata_valid_o : one-cycle strobe when vdata_o carries a new pixel
//   locked_o      : high after lock_cnt consecutive 4-word pixels
//
// state | meaning
// HUNT  | no sync seen since reset, waiting for nDSYNC low
// RED   | sync word captured, next word is R
// GREEN | R captured, next word is G
// BLUE  | G captured, next word is B (pixel is emitted on this edge)
// HOLD  | pixel emitted, waiting for the next sync word
module n64a_vdemux #(
    parameter int color_width_i = 7,
    parameter int color_width_o = 8,
    parameter int lock_cnt      = 8
) (
    input  logic                         VCLK,
    input  logic                         RST,
    input  logic                         nDSYNC,
    input  logic [color_width_i-1:0]     D_i,
    output logic [4+3*color_width_o-1:0] vdata_o,
    output logic                         vdata_valid_o,
    output logic                         locked_o
);

    localparam int GW = $clog2(lock_cnt + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(lock_cnt);

    typedef enum logic [2:0] {HUNT, RED, GREEN, BLUE, HOLD} state_t;

    state_t state, state_n;

    logic                     dsync_q;
    logic [color_width_i-1:0] d_q;
    logic [3:0]               s_q;
    logic [color_width_i-1:0] r_q, g_q;
    logic [2:0]               per_q;
    logic [GW-1:0]            good_q;
    logic                     cap_s, cap_r, cap_g, emit;

    // MSB is replicated into the extra low bits so full scale maps to full scale.
    function automatic logic [color_width_o-1:0] ext(input logic [color_width_i-1:0] c);
        logic [color_width_o-1:0] v;
        v = {color_width_o{c[color_width_i-1]}};
        v[color_width_o-1 -: color_width_i] = c;
        return v;
    endfunction

    always_ff @(posedge VCLK) begin
        if (RST) state <= HUNT;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        cap_s   = 1'b0;
        cap_r   = 1'b0;
        cap_g   = 1'b0;
        emit    = 1'b0;
        if (!dsync_q) begin
            // A sync word always restarts the pixel, discarding any partial one.
            state_n = RED;
            cap_s   = 1'b1;
        end else begin
            case (state)
                RED:   begin cap_r = 1'b1; state_n = GREEN; end
                GREEN: begin cap_g = 1'b1; state_n = BLUE;  end
                BLUE:  begin emit  = 1'b1; state_n = HOLD;  end
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            dsync_q       <= 1'b1;
            d_q           <= '0;
            s_q           <= 4'hF;
            r_q           <= '0;
            g_q           <= '0;
            vdata_o       <= {4'hF, {(3*color_width_o){1'b0}}};
            vdata_valid_o <= 1'b0;
            per_q         <= '0;
            good_q        <= '0;
        end else begin
            dsync_q       <= nDSYNC;
            d_q           <= D_i;
            vdata_valid_o <= emit;
            if (cap_s) s_q <= d_q[3:0];
            if (cap_r) r_q <= d_q;
            if (cap_g) g_q <= d_q;
            // B is taken straight from the input register so the pixel
            // leaves in the same edge that completes it.
            if (emit) vdata_o <= {s_q, ext(r_q), ext(g_q), ext(d_q)};

            // per_q holds the number of edges since the last sync word.
            if (cap_s)             per_q <= 3'd1;
            else if (per_q != 3'd7) per_q <= per_q + 3'd1;

            if (cap_s) begin
                case (state)
                    HOLD: begin
                        if (per_q == 3'd4) begin
                            if (good_q != GOOD_MAX) good_q <= good_q + 1'b1;
                        end else begin
                            good_q <= '0;
                        end
                    end
                    RED, GREEN, BLUE: good_q <= '0;
                    default: good_q <= good_q;
                endcase
            end
        end
    end

    assign locked_o = (good_q == GOOD_MAX);

endmodule

// File: doc/n64a_vdemux.md
N64A_VDEMUX -- requirements
Module: n64a_vdemux

Interface
REQ-001 Parameter color_width_i, default 7: width of the N64 video data bus.
REQ-002 Parameter color_width_o, default 8: width of each demuxed color channel.
REQ-003 Parameter lock_cnt, default 8: number of consecutive well-formed pixels required to assert lock.
REQ-004 VCLK  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 nDSYNC  input  1  data-sync strobe; low marks the sync word of a pixel.
REQ-007 D_i  input  color_width_i  multiplexed N64 video data bus.
REQ-008 vdata_o  output  4+3*color_width_o  registered pixel, packed {S[3:0],R,G,B}; feeds the RGB/YPbPr conversion stage directly.
REQ-009 vdata_valid_o  output  1  one-cycle strobe, high in the cycle vdata_o presents a new pixel.
REQ-010 locked_o  output  1  high while pixel framing is stable.

Function
REQ-011 nDSYNC and D_i SHALL be registered once on entry; all timing below refers to edges at which this input register is loaded.
REQ-012 Phase FSM states: HUNT, RED, GREEN, BLUE, HOLD.
REQ-013 Any edge with registered nDSYNC=0 SHALL capture D[3:0] as S = {nVSYNC,nCLAMP,nHSYNC,nCSYNC} (D3..D0) and enter RED from any state.
REQ-014 RED, GREEN, BLUE with nDSYNC=1 SHALL capture D_i into R, G, B respectively and advance RED->GREEN->BLUE->HOLD.
REQ-015 HUNT and HOLD with nDSYNC=1 SHALL remain in place and capture nothing.
REQ-016 On leaving BLUE, S/R/G/B SHALL be transferred to vdata_o in one edge, and vdata_valid_o SHALL be 1 for exactly that cycle.
REQ-017 Latency: if the sync word is loaded at edge k, vdata_o updates and vdata_valid_o rises at edge k+4.
REQ-018 Width extension: each output channel = {c[color_width_i-1:0], c[color_width_i-1]} (MSB replicated into the LSB); 7'h7F -> 8'hFF, 7'h00 -> 8'h00, 7'h40 -> 8'h81.
REQ-019 vdata_o SHALL hold its value between strobes; an incomplete pixel SHALL never reach vdata_o.
REQ-020 Short pixel: nDSYNC=0 while in RED, GREEN or BLUE SHALL discard the partial pixel, produce no strobe, restart at RED with the new sync word, and clear lock.
REQ-021 Period counter: 3-bit, counts edges since the last sync word and saturates at 7.
REQ-022 Well-formed pixel: period exactly 4 edges (the sync word arrives on the first edge in HOLD).
REQ-023 A period greater than 4 SHALL still complete and strobe its pixel, but SHALL clear lock and the good-pixel counter.
REQ-024 Good-pixel counter: increments per well-formed pixel, saturates at lock_cnt; locked_o=1 once lock_cnt is reached.
REQ-025 Any short or long period SHALL zero the counter and drop locked_o on the following edge.
REQ-026 locked_o SHALL NOT gate vdata_o or vdata_valid_o.

Reset
REQ-027 With RST=1 at an edge: FSM=HUNT, period and good-pixel counters=0, vdata_o = {4'hF, all colors 0}, vdata_valid_o=0, locked_o=0, input register nDSYNC=1.
REQ-028 Reset SHALL take priority over all inputs, including mid-pixel; a partially captured pixel is discarded with no strobe.
REQ-029 The first strobe after reset release SHALL require a complete SYNC,R,G,B sequence.

Verification
REQ-030 Reset then steady 4-cycle stream, sync 4'hB, R=7'h7F, G=7'h00, B=7'h40 -> vdata_o={4'hB,8'hFF,8'h00,8'h81}, strobe 4 edges after each sync word.
REQ-031 8 well-formed pixels -> locked_o rises at the edge after the 8th strobe; after the 7th strobe it is still 0.
REQ-032 Locked stream, then nDSYNC=0 at the GREEN slot -> no strobe for that pixel, locked_o falls, next pixel strobes normally 4 edges later.
REQ-033 Locked stream, then one period of 6 -> pixel strobed with correct data, locked_o falls, relock after 8 good pixels.
REQ-034 RST=1 asserted during the BLUE slot -> outputs return to reset values, no strobe, HUNT until the next nDSYNC=0.
REQ-035 Idle bus with nDSYNC=1 for 100 cycles after reset -> vdata_valid_o never asserts, vdata_o stays {4'hF,0,0,0}.
